mult_div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage of the five-stage pipeline. It accepts a divide request from EX and holds `stallreq_o` high toward the pipeline stall controller while the division runs. When the result is ready it releases `stallreq_o` and presents a 64-bit result: remainder in the high word, quotient in the low word, for the HI/LO write-back path. It supports signed and unsigned division, divide-by-zero and annulment on pipeline flush.

---
 rtl/mult_div_unit_if.sv | 21 ++
 rtl/mult_div_unit.sv | 126 ++++++++++++
 tb/tb_mult_div_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between the EX stage and the multi-cycle divider.
interface mult_div_unit_if;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/mult_div_unit.sv
// Restoring radix-2 32-bit divider, one quotient bit per cycle.
// Result is {remainder, quotient}; stalls the pipeline while busy.
module mult_div_unit (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);

  // state      | meaning
  // ST_FREE    | idle, waiting for start_i
  // ST_BY_ZERO | divisor was zero, result forced to 0
  // ST_ON      | iterating, cnt_q counts completed steps
  // ST_END     | result valid, waiting for start_i to drop
  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_BY_ZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_abs, op2_abs;
  logic [32:0] diff;
  logic [31:0] quo_fix, rem_fix;

  // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
  always_comb begin
    op1_abs = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    op2_abs = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    diff    = work_q[63:31] - {1'b0, divisor_q};
    quo_fix = q_neg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    rem_fix = r_neg_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      ST_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          work_d    = {32'd0, op1_abs};
          divisor_d = op2_abs;
          q_neg_d   = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
          r_neg_d   = bus.signed_div_i && bus.opdata1_i[31];
          cnt_d     = 6'd0;
          state_d   = (bus.opdata2_i == 32'd0) ? ST_BY_ZERO : ST_ON;
        end
      end
      ST_BY_ZERO: begin
        result_d = 64'd0;
        ready_d  = 1'b1;
        state_d  = ST_END;
      end
      ST_ON: begin
        if (bus.annul_i) begin
          result_d = 64'd0;
          ready_d  = 1'b0;
          cnt_d    = 6'd0;
          state_d  = ST_FREE;
        end else if (cnt_q == 6'd32) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = ST_END;
        end else begin
          // diff's top bit is a true sign: the shifted remainder is below 2*divisor.
          if (!diff[32]) begin
            work_d = {diff[31:0], work_q[30:0], 1'b1};
          end else begin
            work_d = {work_q[62:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_END: begin
        if (!bus.start_i) begin
          result_d = 64'd0;
          ready_d  = 1'b0;
          state_d  = ST_FREE;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= 6'd0;
      work_q    <= 64'd0;
      divisor_q <= 32'd0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  // Gated by rst so the stall drops the instant reset asserts.
  assign bus.stallreq_o = rst & bus.start_i & ~ready_q & ~bus.annul_i;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic reference.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mult_div_unit_if u_if ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, latency/stall count, result, optional END hold, release.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit hold);
    int          edges;
    int          stalls;
    logic [63:0] exp;
    logic [63:0] res;
    exp = ref_div(a, b, sgn);
    u_if.opdata1_i    = a;
    u_if.opdata2_i    = b;
    u_if.signed_div_i = sgn;
    u_if.start_i      = 1'b1;
    #1;
    edges  = 0;
    stalls = 0;
    while (!u_if.ready_o && edges < 100) begin
      if (u_if.stallreq_o) stalls++;
      step();
      edges++;
      if (edges >= 1 && !u_if.ready_o) begin
        u_if.opdata1_i    = $urandom;
        u_if.opdata2_i    = $urandom;
        u_if.signed_div_i = 1'($urandom_range(0, 1));
      end
    end
    check("latency_edges", 64'(edges), (b == 32'd0) ? 64'd2 : 64'd34);
    check("stall_cycles", 64'(stalls), (b == 32'd0) ? 64'd2 : 64'd34);
    check("result", u_if.result_o, exp);
    check("stall_low_in_end", 64'(u_if.stallreq_o), 64'd0);
    res = u_if.result_o;
    if (hold) begin
      step();
      check("end_hold_ready", 64'(u_if.ready_o), 64'd1);
      check("end_hold_result", u_if.result_o, exp);
    end
    u_if.start_i = 1'b0;
    step();
    check("release_ready", 64'(u_if.ready_o), 64'd0);
    check("release_result", u_if.result_o, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit          sgn;
    int          mode;

    u_if.start_i      = 1'b1;
    u_if.annul_i      = 1'b0;
    u_if.signed_div_i = 1'b0;
    u_if.opdata1_i    = 32'd100;
    u_if.opdata2_i    = 32'd7;
    #12;
    check("reset_result", u_if.result_o, 64'd0);
    check("reset_ready", 64'(u_if.ready_o), 64'd0);
    check("reset_stall", 64'(u_if.stallreq_o), 64'd0);
    u_if.start_i = 1'b0;
    step();
    rst = 1'b1;
    step();

    do_div(32'd100, 32'd7, 1'b0, 1'b1);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    do_div(32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    do_div(32'h12345678, 32'd0, 1'b0, 1'b1);
    do_div(32'h80000001, 32'd0, 1'b1, 1'b0);

    // Annul during the tenth ON cycle.
    u_if.opdata1_i    = 32'd12345;
    u_if.opdata2_i    = 32'd67;
    u_if.signed_div_i = 1'b0;
    u_if.start_i      = 1'b1;
    step();
    repeat (9) step();
    u_if.annul_i = 1'b1;
    #1;
    check("annul_stall", 64'(u_if.stallreq_o), 64'd0);
    step();
    check("annul_ready", 64'(u_if.ready_o), 64'd0);
    check("annul_result", u_if.result_o, 64'd0);
    u_if.annul_i = 1'b0;
    u_if.start_i = 1'b0;
    step();
    do_div(32'd20, 32'd3, 1'b0, 1'b0);

    // Reset pulsed mid-ON between clock edges.
    u_if.opdata1_i = 32'd999;
    u_if.opdata2_i = 32'd10;
    u_if.start_i   = 1'b1;
    #1;
    repeat (6) step();
    #2;
    rst = 1'b0;
    #1;
    check("rst_on_stall", 64'(u_if.stallreq_o), 64'd0);
    check("rst_on_ready", 64'(u_if.ready_o), 64'd0);
    check("rst_on_result", u_if.result_o, 64'd0);
    #1;
    rst = 1'b1;
    do_div(32'hDEADBEEF, 32'd12345, 1'b1, 1'b1);

    // Reset asserted while a result is held in END.
    u_if.opdata1_i    = 32'd50;
    u_if.opdata2_i    = 32'd6;
    u_if.signed_div_i = 1'b0;
    u_if.start_i      = 1'b1;
    #1;
    repeat (36) step();
    check("pre_rst_end_ready", 64'(u_if.ready_o), 64'd1);
    check("pre_rst_end_result", u_if.result_o, {32'd2, 32'd8});
    #2;
    rst = 1'b0;
    #1;
    check("rst_end_ready", 64'(u_if.ready_o), 64'd0);
    check("rst_end_result", u_if.result_o, 64'd0);
    check("rst_end_stall", 64'(u_if.stallreq_o), 64'd0);
    #1;
    rst = 1'b1;
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(0, 5));
      sgn  = 1'($urandom_range(0, 1));
      a    = $urandom;
      case (mode)
        0:       b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = (sgn) ? -32'($urandom_range(1, 1000)) : 32'($urandom_range(1, 1000));
        default: b = $urandom;
      endcase
      do_div(a, b, sgn, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
